inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader_pkg.sv | 22 ++
 rtl/rsp_fifo2.sv | 76 +++++++
 rtl/inst_mem_loader.sv | 142 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: sizes, FSM encoding
// and the fetch address legality rule used by the loader top.
package inst_mem_loader_pkg;

    localparam int DEPTH_DEFAULT = 64;
    localparam int WORD_W        = 32;
    localparam int RSP_W         = WORD_W + 1;
    localparam int COUNT_W       = 7;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A fetch is rejected when the PC is not word aligned or points past the
    // last instruction word held in the array.
    function automatic logic fetch_is_bad(input logic [WORD_W-1:0] addr,
                                          input int unsigned      depth);
        return (addr[1:0] != 2'b00) || (addr >= 4 * depth);
    endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO with fall-through: when empty, an incoming word is
// presented on the output in the same cycle and only stored if not taken.
module rsp_fifo2
    import inst_mem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [RSP_W-1:0] in_data,
    output logic             out_valid,
    output logic [RSP_W-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [RSP_W-1:0] slot_q [2];
    logic [RSP_W-1:0] slot_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             empty;
    logic             push;
    logic             pop;

    // Output selection, push/pop decisions and next pointer/occupancy values.
    always_comb begin
        slot_d    = slot_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        empty     = (count_q == 2'd0);
        out_valid = !empty || in_valid;
        out_data  = '0;
        pop       = 1'b0;
        push      = 1'b0;

        if (!empty) begin
            out_data = slot_q[rd_ptr_q];
        end else if (in_valid) begin
            out_data = in_data;
        end

        pop  = !empty && out_ready;
        push = in_valid && !(empty && out_ready);

        if (push) begin
            slot_d[wr_ptr_q] = in_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage slots carry no reset; stale contents are never shown as valid.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign count = count_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: accepts a program image word by word, then
// serves in-order instruction fetches through a two-entry response FIFO.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    input  logic [WORD_W-1:0]   ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    input  logic                f_req_valid,
    input  logic [WORD_W-1:0]   f_req_addr,
    output logic                f_req_ready,
    output logic                f_rsp_valid,
    output logic [WORD_W-1:0]   f_rsp_data,
    output logic                f_rsp_err,
    input  logic                f_rsp_ready,
    output logic                loaded,
    output logic [COUNT_W-1:0]  ld_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  ld_count_q, ld_count_d;
    logic                inflight_q, inflight_d;
    logic                bad_q, bad_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic [WORD_W-1:0]   rd_data_q;
    logic                mem_we;
    logic [IDX_W-1:0]    mem_addr;

    logic                ld_fire;
    logic                fetch_fire;
    logic [1:0]          fifo_count;
    logic [1:0]          outstanding;
    logic                rsp_in_valid;
    logic [RSP_W-1:0]    rsp_in_data;
    logic [RSP_W-1:0]    rsp_out_data;

    // Load/run sequencing: count accepted words and switch to RUN on the
    // last word of the image or when the array is full.
    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        ld_ready   = 1'b0;
        ld_fire    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ld_ready = 1'b1;
                ld_fire  = ld_valid;
                if (ld_fire) begin
                    ld_count_d = ld_count_q + COUNT_W'(1);
                    if (ld_last || (ld_count_q == COUNT_W'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and word counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            ld_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
        end
    end

    // Fetch acceptance is throttled so that buffered plus in-flight responses
    // never exceed the FIFO capacity; the single memory port is shared by
    // the loader (LOAD) and the fetch path (RUN).
    always_comb begin
        outstanding  = fifo_count + {1'b0, inflight_q};
        f_req_ready  = (state_q == ST_RUN) && (outstanding < 2'd2);
        fetch_fire   = f_req_valid && f_req_ready;
        inflight_d   = fetch_fire;
        bad_d        = 1'b0;
        if (fetch_fire) begin
            bad_d = fetch_is_bad(f_req_addr, DEPTH);
        end
        mem_we   = ld_fire;
        mem_addr = f_req_addr[IDX_W+1:2];
        if (state_q == ST_LOAD) begin
            mem_addr = ld_count_q[IDX_W-1:0];
        end
        rsp_in_valid = inflight_q;
        rsp_in_data  = {1'b0, rd_data_q};
        if (bad_q) begin
            rsp_in_data = {1'b1, {WORD_W{1'b0}}};
        end
    end

    // Tracks the read issued last cycle and whether it was an illegal address.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            bad_q      <= bad_d;
        end
    end

    // Single-port synchronous-read array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= ld_data;
        end
        rd_data_q <= mem_q[mem_addr];
    end

    rsp_fifo2 u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rsp_in_valid),
        .in_data   (rsp_in_data),
        .out_valid (f_rsp_valid),
        .out_data  (rsp_out_data),
        .out_ready (f_rsp_ready),
        .count     (fifo_count)
    );

    assign f_rsp_err  = rsp_out_data[RSP_W-1];
    assign f_rsp_data = rsp_out_data[WORD_W-1:0];
    assign loaded     = (state_q == ST_RUN);
    assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader against a
// transaction-level model of the program image and the response stream.
module tb_inst_mem_loader;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
    logic        f_rsp_err;
    logic        f_rsp_ready;
    logic        loaded;
    logic [6:0]  ld_count;

    inst_mem_loader #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .f_rsp_ready (f_rsp_ready),
        .loaded      (loaded),
        .ld_count    (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] data;
        bit          known;
    } rsp_t;

    rsp_t        rspQ[$];
    logic [31:0] modelMem [DEPTH];
    bit          modelKnown [DEPTH];
    int          modelCount;
    bit          modelLoaded;
    bit          lastReqReady;
    int          testCount = 0;
    int          failCount = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // What a fetch of this byte address should return, from the image so far.
    function automatic rsp_t expectedRsp(input logic [31:0] addr);
        rsp_t r;
        int   idx;
        if ((addr % 4) != 0 || addr >= 32'(4 * DEPTH)) begin
            r.err = 1'b1; r.data = 32'h0; r.known = 1'b1;
        end else begin
            idx     = int'(addr / 4);
            r.err   = 1'b0;
            r.data  = modelMem[idx];
            r.known = modelKnown[idx];
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model by whatever handshakes the model says occur.
    task automatic applyStimulus(input bit ldv, input logic [31:0] ldd, input bit ldl,
                                 input bit frv, input logic [31:0] fra, input bit frr,
                                 output bit fetchTaken);
        bit   expReady;
        rsp_t head;
        @(negedge clk);
        ld_valid    = ldv;
        ld_data     = ldd;
        ld_last     = ldl;
        f_req_valid = frv;
        f_req_addr  = fra;
        f_rsp_ready = frr;
        #1;
        expReady     = modelLoaded && (rspQ.size() < 2);
        lastReqReady = f_req_ready;
        checkOutput("ld_ready", 32'(ld_ready), 32'(!modelLoaded));
        checkOutput("loaded", 32'(loaded), 32'(modelLoaded));
        checkOutput("ld_count", 32'(ld_count), 32'(modelCount));
        checkOutput("f_req_ready", 32'(f_req_ready), 32'(expReady));
        checkOutput("f_rsp_valid", 32'(f_rsp_valid), 32'(rspQ.size() > 0));
        if (rspQ.size() > 0) begin
            head = rspQ[0];
            checkOutput("f_rsp_err", 32'(f_rsp_err), 32'(head.err));
            if (head.known) checkOutput("f_rsp_data", f_rsp_data, head.data);
        end
        if (rspQ.size() > 0 && frr) void'(rspQ.pop_front());
        fetchTaken = frv && expReady;
        if (fetchTaken) rspQ.push_back(expectedRsp(fra));
        if (ldv && !modelLoaded) begin
            modelMem[modelCount]   = ldd;
            modelKnown[modelCount] = 1'b1;
            modelCount++;
            if (ldl || modelCount == DEPTH) modelLoaded = 1'b1;
        end
    endtask

    task automatic idleCycles(input int n, input bit frr);
        bit t;
        repeat (n) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, frr, t);
    endtask

    task automatic loadWord(input logic [31:0] d, input bit last);
        bit t;
        applyStimulus(1'b1, d, last, 1'b0, 32'h0, 1'b1, t);
    endtask

    task automatic fetchAddr(input logic [31:0] a, input bit frr);
        bit t;
        int tries;
        t = 1'b0;
        tries = 0;
        while (!t && tries < 20) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, a, frr, t);
            tries++;
        end
        checkOutput("fetch_accepted", 32'(lastReqReady), 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ld_valid = 1'b0; ld_last = 1'b0; f_req_valid = 1'b0; f_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        rspQ.delete();
        modelCount  = 0;
        modelLoaded = 1'b0;
        checkOutput("rst_ld_count", 32'(ld_count), 32'd0);
        checkOutput("rst_loaded", 32'(loaded), 32'd0);
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("rst_f_req_ready", 32'(f_req_ready), 32'd0);
        checkOutput("rst_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
        checkOutput("rst_f_rsp_err", 32'(f_rsp_err), 32'd0);
        checkOutput("rst_f_rsp_data", f_rsp_data, 32'd0);
    endtask

    function automatic logic [31:0] randomAddr(input int knownWords);
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
            1:       a = 32'(4 * DEPTH) + $urandom_range(0, 255) * 4;
            default: a = $urandom_range(0, knownWords - 1) * 4;
        endcase
        return a;
    endfunction

    initial begin
        bit t;
        int accepted;
        int guard;
        rst = 1'b1;
        ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
        f_req_valid = 1'b0; f_req_addr = 32'h0; f_rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) modelKnown[i] = 1'b0;
        modelCount = 0;
        modelLoaded = 1'b0;

        doReset();

        loadWord(32'h20080005, 1'b0);
        loadWord(32'h20090007, 1'b0);
        loadWord(32'h01095020, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("prog_count", 32'(ld_count), 32'd3);

        fetchAddr(32'h0, 1'b1);
        fetchAddr(32'h4, 1'b1);
        fetchAddr(32'h8, 1'b1);
        idleCycles(3, 1'b1);

        fetchAddr(32'h6, 1'b1);
        fetchAddr(32'h100, 1'b1);
        idleCycles(3, 1'b1);

        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'((accepted % 3) * 4), 1'b0, t);
            if (lastReqReady) accepted++;
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd2);
        idleCycles(3, 1'b0);
        idleCycles(4, 1'b1);

        repeat (300) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), randomAddr(3),
                          1'($urandom_range(0, 3) != 0), t);
        end
        idleCycles(4, 1'b1);

        doReset();
        guard = 0;
        while (modelCount < DEPTH && guard < 500) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'b0,
                          1'($urandom_range(0, 1)), randomAddr(1), 1'b1, t);
            guard++;
        end
        checkOutput("full_loaded", 32'(modelCount), 32'(DEPTH));
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b1, t);
        idleCycles(1, 1'b1);
        checkOutput("count_after_extra", 32'(ld_count), 32'(DEPTH));

        repeat (400) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'($urandom_range(0, 3) != 0),
                          randomAddr(DEPTH), 1'($urandom_range(0, 2) != 0), t);
        end
        idleCycles(4, 1'b1);

        doReset();
        loadWord($urandom, 1'b0);
        loadWord($urandom, 1'b0);
        doReset();
        loadWord(32'hDEADBEEF, 1'b1);
        idleCycles(1, 1'b1);
        fetchAddr(32'h0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("reload_data", f_rsp_data, 32'hDEADBEEF);
        idleCycles(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
